// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing, types and the operand bypass helper for the register file and its
// pending-write scoreboard.
package regfile_scoreboard_pkg;

  parameter int unsigned XLEN       = 32;
  parameter int unsigned NREG       = 32;
  parameter int unsigned REG_ADDR_W = 5;
  parameter int unsigned CNT_W      = 2;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  parameter cnt_t CNT_MAX = '1;

  // x0 reads zero; a same-cycle writeback overrides the stored value.
  function automatic word_t read_operand(input reg_addr_t addr, input logic we,
                                         input reg_addr_t wa, input word_t wd,
                                         input word_t stored);
    if (addr == '0) begin
      return '0;
    end
    if (we && (wa == addr)) begin
      return wd;
    end
    return stored;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, operand-read and issue signals between the pipeline (master) and the
// register file / scoreboard (slave).
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic      rf_write_en;
  reg_addr_t rf_write_addr;
  word_t     rf_write_data;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  word_t     rs1_data;
  word_t     rs2_data;
  logic      rs1_busy;
  logic      rs2_busy;
  logic      iss_valid;
  logic      iss_regwrite;
  reg_addr_t iss_rd;
  logic      iss_stall;
  logic      sb_error;

  modport master (
    output rf_write_en, rf_write_addr, rf_write_data, rs1_addr, rs2_addr,
           iss_valid, iss_regwrite, iss_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_stall, sb_error
  );

  modport slave (
    input  rf_write_en, rf_write_addr, rf_write_data, rs1_addr, rs2_addr,
           iss_valid, iss_regwrite, iss_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_stall, sb_error
  );

endinterface

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register; err pulses on an increment at
// max or a decrement at zero, and the count then holds.
module sb_counter
  import regfile_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output cnt_t count,
  output logic err
);

  cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    err     = 1'b0;
    if (inc && !dec) begin
      if (count_q == CNT_MAX) begin
        err = 1'b1;
      end else begin
        count_d = count_q + cnt_t'(1);
      end
    end else if (dec && !inc) begin
      if (count_q == '0) begin
        err = 1'b1;
      end else begin
        count_d = count_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with writeback bypass and a per-register scoreboard of
// in-flight writers for RAW hazard detection at decode.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);

  word_t            mem_q [NREG];
  cnt_t             cnt   [NREG];
  logic [NREG-1:1]  inc_hit;
  logic [NREG-1:1]  dec_hit;
  logic [NREG-1:1]  err;
  logic             inc;
  logic             dec;
  logic             sb_error_q;
  logic             rs1_ret;
  logic             rs2_ret;
  logic             rd_ret;

  assign inc = bus.iss_valid & bus.iss_regwrite & (bus.iss_rd != '0);
  assign dec = bus.rf_write_en & (bus.rf_write_addr != '0);

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign inc_hit[r] = inc & (bus.iss_rd == reg_addr_t'(r));
    assign dec_hit[r] = dec & (bus.rf_write_addr == reg_addr_t'(r));

    sb_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_hit[r]),
      .dec   (dec_hit[r]),
      .count (cnt[r]),
      .err   (err[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      if (dec) begin
        mem_q[bus.rf_write_addr] <= bus.rf_write_data;
      end
      sb_error_q <= sb_error_q | (|err);
    end
  end

  // A writer retiring this cycle no longer counts: its data arrives via the bypass.
  always_comb begin
    rs1_ret = dec & (bus.rf_write_addr == bus.rs1_addr);
    rs2_ret = dec & (bus.rf_write_addr == bus.rs2_addr);
    rd_ret  = dec & (bus.rf_write_addr == bus.iss_rd);

    bus.rs1_data = read_operand(bus.rs1_addr, bus.rf_write_en, bus.rf_write_addr,
                                bus.rf_write_data, mem_q[bus.rs1_addr]);
    bus.rs2_data = read_operand(bus.rs2_addr, bus.rf_write_en, bus.rf_write_addr,
                                bus.rf_write_data, mem_q[bus.rs2_addr]);

    bus.rs1_busy = (bus.rs1_addr != '0) && (cnt[bus.rs1_addr] > cnt_t'(rs1_ret));
    bus.rs2_busy = (bus.rs2_addr != '0) && (cnt[bus.rs2_addr] > cnt_t'(rs2_ret));

    bus.iss_stall = bus.iss_regwrite && (bus.iss_rd != '0) &&
                    (cnt[bus.iss_rd] == CNT_MAX) && !rd_ret;
  end

  assign bus.sb_error = sb_error_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed walk through the hazard scenarios, then randomized traffic checked against
// an array-and-counter reference model.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  localparam int MaxCnt = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'h0;
    if (bus.rf_write_en && int'(bus.rf_write_addr) == a) return bus.rf_write_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input int a);
    int pending;
    pending = m_cnt[a];
    if (bus.rf_write_en && bus.rf_write_addr != 0 && int'(bus.rf_write_addr) == a)
      pending--;
    return (a != 0) && (pending > 0);
  endfunction

  function automatic logic m_stall();
    int rd;
    rd = int'(bus.iss_rd);
    return bus.iss_regwrite && rd != 0 && m_cnt[rd] == MaxCnt &&
           !(bus.rf_write_en && int'(bus.rf_write_addr) == rd);
  endfunction

  task automatic idle();
    bus.rf_write_en   = 1'b0;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    bus.iss_valid     = 1'b0;
    bus.iss_regwrite  = 1'b0;
    bus.iss_rd        = '0;
  endtask

  // Inputs are already driven (negedge); let them settle and compare against the model.
  task automatic settle_check();
    #1;
    check("rs1_data", bus.rs1_data, m_read(int'(bus.rs1_addr)));
    check("rs2_data", bus.rs2_data, m_read(int'(bus.rs2_addr)));
    check("rs1_busy", 32'(bus.rs1_busy), 32'(m_busy(int'(bus.rs1_addr))));
    check("rs2_busy", 32'(bus.rs2_busy), 32'(m_busy(int'(bus.rs2_addr))));
    check("iss_stall", 32'(bus.iss_stall), 32'(m_stall()));
    check("sb_error", 32'(bus.sb_error), 32'(m_err));
  endtask

  task automatic tick();
    bit inc, dec, ih, dh;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_cnt[i]  = 0;
      end
      m_err = 1'b0;
    end else begin
      inc = bus.iss_valid && bus.iss_regwrite && bus.iss_rd != 0;
      dec = bus.rf_write_en && bus.rf_write_addr != 0;
      for (int r = 1; r < 32; r++) begin
        ih = inc && int'(bus.iss_rd) == r;
        dh = dec && int'(bus.rf_write_addr) == r;
        if (ih && !dh) begin
          if (m_cnt[r] == MaxCnt) m_err = 1'b1;
          else m_cnt[r]++;
        end else if (dh && !ih) begin
          if (m_cnt[r] == 0) m_err = 1'b1;
          else m_cnt[r]--;
        end
      end
      if (dec) m_regs[bus.rf_write_addr] = bus.rf_write_data;
    end
    @(negedge clk);
  endtask

  task automatic issue(input int rd);
    idle();
    bus.iss_valid    = 1'b1;
    bus.iss_regwrite = 1'b1;
    bus.iss_rd       = reg_addr_t'(rd);
  endtask

  task automatic writeback(input int rd, input logic [31:0] d);
    bus.rf_write_en   = 1'b1;
    bus.rf_write_addr = reg_addr_t'(rd);
    bus.rf_write_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_err = 1'b0;
    tick();
    tick();

    // Reset state.
    rst_n = 1'b1;
    bus.rs1_addr = 5'd5;
    settle_check();
    check("rst_x5", bus.rs1_data, 32'h0);
    check("rst_x0", bus.rs2_data, 32'h0);
    check("rst_busy", 32'(bus.rs1_busy), 32'h0);
    check("rst_err", 32'(bus.sb_error), 32'h0);
    tick();

    // RAW hazard on x3, resolved by bypass then array.
    issue(3);
    settle_check();
    tick();
    idle();
    bus.rs1_addr = 5'd3;
    settle_check();
    check("x3_busy_t1", 32'(bus.rs1_busy), 32'h1);
    tick();
    settle_check();
    tick();
    writeback(3, 32'hDEADBEEF);
    settle_check();
    check("x3_bypass", bus.rs1_data, 32'hDEADBEEF);
    check("x3_busy_wb", 32'(bus.rs1_busy), 32'h0);
    tick();
    idle();
    bus.rs1_addr = 5'd3;
    settle_check();
    check("x3_array", bus.rs1_data, 32'hDEADBEEF);
    tick();

    // x0 is never written and never busy.
    issue(0);
    writeback(0, 32'h1234);
    settle_check();
    check("x0_stall", 32'(bus.iss_stall), 32'h0);
    tick();
    idle();
    settle_check();
    check("x0_read", bus.rs1_data, 32'h0);
    check("x0_busy", 32'(bus.rs1_busy), 32'h0);
    check("x0_err", 32'(bus.sb_error), 32'h0);
    tick();

    // Saturation on x7.
    for (int i = 0; i < 3; i++) begin
      issue(7);
      settle_check();
      tick();
    end
    issue(7);
    bus.iss_valid = 1'b0;
    settle_check();
    check("x7_stall", 32'(bus.iss_stall), 32'h1);
    bus.iss_valid = 1'b1;
    writeback(7, 32'h7777);
    settle_check();
    check("x7_stall_wb", 32'(bus.iss_stall), 32'h0);
    tick();
    issue(7);
    bus.iss_valid = 1'b0;
    settle_check();
    check("x7_still3", 32'(bus.iss_stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle();
      writeback(7, 32'h70 + 32'(i));
      settle_check();
      tick();
    end

    // Simultaneous issue and writeback on x9 with count 1.
    issue(9);
    settle_check();
    tick();
    issue(9);
    writeback(9, 32'h9999);
    bus.rs1_addr = 5'd9;
    settle_check();
    check("x9_busy_same", 32'(bus.rs1_busy), 32'h0);
    tick();
    idle();
    bus.rs1_addr = 5'd9;
    settle_check();
    check("x9_busy_after", 32'(bus.rs1_busy), 32'h1);
    check("x9_err", 32'(bus.sb_error), 32'h0);
    tick();

    // Underflow on x4, then mid-stream reset.
    idle();
    issue(10);
    writeback(4, 32'hC0FFEE04);
    settle_check();
    tick();
    idle();
    bus.rs1_addr = 5'd4;
    bus.rs2_addr = 5'd10;
    settle_check();
    check("x4_data", bus.rs1_data, 32'hC0FFEE04);
    check("x4_err", 32'(bus.sb_error), 32'h1);
    tick();
    rst_n = 1'b0;
    issue(11);
    settle_check();
    tick();
    rst_n = 1'b1;
    idle();
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd11;
    settle_check();
    check("rst_err_clr", 32'(bus.sb_error), 32'h0);
    check("rst_x9_busy", 32'(bus.rs1_busy), 32'h0);
    check("rst_x11_busy", 32'(bus.rs2_busy), 32'h0);
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      rst_n             = ($urandom_range(0, 79) != 0);
      bus.rf_write_en   = $urandom_range(0, 1) == 1;
      bus.rf_write_addr = reg_addr_t'($urandom_range(0, 7));
      bus.rf_write_data = $urandom;
      bus.iss_valid     = $urandom_range(0, 1) == 1;
      bus.iss_regwrite  = $urandom_range(0, 3) != 0;
      bus.iss_rd        = reg_addr_t'($urandom_range(0, 7));
      bus.rs1_addr      = reg_addr_t'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31)
                                                                : $urandom_range(0, 7));
      bus.rs2_addr      = reg_addr_t'($urandom_range(0, 7));
      settle_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
